sram_arbiter: RTL and testbench

- Shares one sram-like memory port between the CPU's instruction fetch and data access ports.
- Sequences each access as a request/addr_ok phase followed by a data_ok phase.
- Generates i_stall / d_stall back to the CPU.
- Holds each completed result until the pipeline releases it, so a frozen pipeline does not re-issue the access.
- Sits between the sram-wrapped MIPS core and the memory/bus bridge.

---
 rtl/sram_arbiter.sv | 156 +++++++++++++++
 tb/tb_sram_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one sram-like memory port.
// One transaction is in flight at a time, and each one runs as a request/addr_ok
// phase followed by a data_ok phase. A completed result is held in a per-port
// done flag while the pipeline is frozen, so the same access is not issued twice.
module sram_arbiter #(
  parameter bit          DATA_FIRST = 1'b1,
  parameter logic [31:0] ADDR_MASK  = 32'h1FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  output logic        i_stall,

  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        d_stall,

  input  logic        longest_stall,
  input  logic        exceptflush,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    D_ADDR,
    D_DATA,
    I_ADDR,
    I_DATA
  } state_t;

  state_t      state;
  logic [31:0] req_addr;   // untranslated address of the current request
  logic        i_done;     // fetch result is valid and held for the pipeline
  logic        d_done;     // data result is valid and held for the pipeline
  logic        i_discard;  // fetch in flight was flushed; drop its data
  logic        pend_i;
  logic        pend_d;
  logic        pick_d;

  // A port needs service while it requests and has no held result.
  assign pend_i  = inst_sram_en & ~i_done;
  assign pend_d  = data_sram_en & ~d_done;
  assign i_stall = pend_i;
  assign d_stall = pend_d;

  // The data port wins a simultaneous request only when DATA_FIRST is set.
  assign pick_d = pend_d & (DATA_FIRST | ~pend_i);

  // kseg0/kseg1 addresses are folded onto the physical space. All other addresses pass through.
  assign mem_addr = (req_addr[31:30] == 2'b10) ? (req_addr & ADDR_MASK) : req_addr;

  // Request sequencer, done-flag bookkeeping and result capture.
  // NOTE: every register in this block uses non-blocking assignments, so all
  // reads in a cycle see the pre-edge values. A later assignment in the same
  // cycle overrides an earlier one, and the release code below relies on that.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the datapath registers are reset along with the control state,
      // so the memory port and the rdata outputs start at 0 and never show X.
      state           <= IDLE;
      mem_req         <= 1'b0;
      mem_wr          <= 1'b0;
      mem_wstrb       <= 4'h0;
      req_addr        <= 32'h0;
      mem_wdata       <= 32'h0;
      i_done          <= 1'b0;
      d_done          <= 1'b0;
      i_discard       <= 1'b0;
      inst_sram_rdata <= 32'h0;
      data_sram_rdata <= 32'h0;
    end else begin
      // A held result is released on the first cycle the pipeline advances.
      if (d_done && !longest_stall) d_done <= 1'b0;
      if (exceptflush)                     i_done <= 1'b0;
      else if (i_done && !longest_stall)   i_done <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_d) begin
            state     <= D_ADDR;
            mem_req   <= 1'b1;
            mem_wr    <= |data_sram_wen;
            mem_wstrb <= data_sram_wen;
            req_addr  <= data_sram_addr;
            mem_wdata <= data_sram_wdata;
          end else if (pend_i) begin
            state     <= I_ADDR;
            mem_req   <= 1'b1;
            mem_wr    <= 1'b0;
            mem_wstrb <= 4'h0;
            req_addr  <= inst_sram_addr;
            mem_wdata <= 32'h0;
          end
        end

        D_ADDR: begin
          if (mem_addr_ok) begin
            mem_req <= 1'b0;
            state   <= D_DATA;
          end
        end

        D_DATA: begin
          if (mem_data_ok) begin
            if (!mem_wr) data_sram_rdata <= mem_rdata;
            d_done <= 1'b1;
            state  <= IDLE;
          end
        end

        I_ADDR: begin
          // Once accepted, a request has to finish. A flush in the same cycle
          // only marks its data for discard.
          if (mem_addr_ok) begin
            mem_req   <= 1'b0;
            i_discard <= exceptflush;
            state     <= I_DATA;
          end else if (exceptflush) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end

        I_DATA: begin
          if (mem_data_ok) begin
            i_discard <= 1'b0;
            if (!(i_discard || exceptflush)) begin
              inst_sram_rdata <= mem_rdata;
              i_done          <= 1'b1;
            end
            state <= IDLE;
          end else if (exceptflush) begin
            i_discard <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter. The bench plays the CPU and also the memory.
// A reference memory, indexed by physical word address, gives the expected
// load and fetch data. The memory responder keeps a separate "system" memory
// that only changes through writes the DUT actually performs.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        i_stall;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        d_stall;
  logic        longest_stall;
  logic        exceptflush;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata   = 32'h0;

  sram_arbiter #(
    .DATA_FIRST (1'b1),
    .ADDR_MASK  (32'h1FFF_FFFF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .i_stall         (i_stall),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .d_stall         (d_stall),
    .longest_stall   (longest_stall),
    .exceptflush     (exceptflush),
    .mem_req         (mem_req),
    .mem_wr          (mem_wr),
    .mem_wstrb       (mem_wstrb),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_addr_ok     (mem_addr_ok),
    .mem_data_ok     (mem_data_ok),
    .mem_rdata       (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] sys_mem [logic [31:0]];
  logic [31:0] exp_inst_rdata = 32'h0;
  logic [31:0] exp_data_rdata = 32'h0;
  int          last_i_cyc;
  int          last_d_cyc;

  // kseg0/kseg1 map onto the low 512 MB. Other segments are used as-is.
  function automatic logic [31:0] xlate(input logic [31:0] a);
    return (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
  endfunction

  function automatic logic [31:0] key(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return key(a) ^ 32'hA5C3_0F96;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] s,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(key(a)) ? ref_mem[key(a)] : init_word(a);
  endfunction

  function automatic logic [31:0] sys_read(input logic [31:0] a);
    return sys_mem.exists(key(a)) ? sys_mem[key(a)] : init_word(a);
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
    ref_mem[key(a)] = merge(ref_read(a), s, wd);
  endtask

  task automatic sys_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
    sys_mem[key(a)] = merge(sys_read(a), s, wd);
  endtask

  task automatic preload(input logic [31:0] pa, input logic [31:0] v);
    ref_mem[key(pa)] = v;
    sys_mem[key(pa)] = v;
  endtask

  // ---------------- memory responder ----------------
  int          addr_delay  = 0;
  int          data_delay  = 0;
  bit          rand_delays = 1'b0;
  int          txn_count   = 0;
  bit          r_data      = 1'b0;
  int          r_cnt       = 0;
  logic [31:0] seen_addr, seen_wdata;
  logic        seen_wr;
  logic [3:0]  seen_wstrb;

  task automatic score();
    txn_t e;
    if (exp_q.size() == 0) begin
      check("req_expected", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("req_addr", seen_addr, e.addr);
      check("req_wr", 32'(seen_wr), 32'(e.wr));
      check("req_wstrb", 32'(seen_wstrb), 32'(e.wstrb));
      if (e.wr) check("req_wdata", seen_wdata, e.wdata);
    end
  endtask

  // Accepts each request after addr_delay cycles and answers after data_delay more.
  always @(negedge clk) begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = $urandom;
    if (!rst) begin
      r_data = 1'b0;
      r_cnt  = 0;
    end else if (!r_data) begin
      if (!mem_req) begin
        r_cnt = 0;
      end else begin
        if (r_cnt == 0) begin
          seen_addr  = mem_addr;
          seen_wr    = mem_wr;
          seen_wstrb = mem_wstrb;
          seen_wdata = mem_wdata;
          if (rand_delays) addr_delay = $urandom_range(0, 3);
        end else begin
          check("req_stable_addr", mem_addr, seen_addr);
          check("req_stable_wr", 32'(mem_wr), 32'(seen_wr));
          check("req_stable_wstrb", 32'(mem_wstrb), 32'(seen_wstrb));
          check("req_stable_wdata", mem_wdata, seen_wdata);
        end
        if (r_cnt >= addr_delay) begin
          mem_addr_ok = 1'b1;
          r_data      = 1'b1;
          r_cnt       = 0;
          txn_count++;
          score();
          if (rand_delays) data_delay = $urandom_range(0, 3);
        end else begin
          r_cnt++;
        end
      end
    end else begin
      if (r_cnt >= data_delay) begin
        mem_data_ok = 1'b1;
        r_data      = 1'b0;
        r_cnt       = 0;
        if (seen_wr) sys_write(seen_addr, seen_wstrb, seen_wdata);
        else         mem_rdata = sys_read(seen_addr);
      end else begin
        r_cnt++;
      end
    end
  end

  // ---------------- CPU-side tasks ----------------
  // Issues a fetch and/or data access in one cycle and holds each port until it
  // completes. It then keeps the port while longest_stall is high and releases it
  // once the pipeline advances. A nonzero hold_ls keeps longest_stall high until
  // hold_ls cycles after completion.
  task automatic access(input bit do_i, input logic [31:0] ia, input bit do_d,
                        input logic [3:0] wen, input logic [31:0] da, input logic [31:0] wd,
                        input bit rand_ls, input int hold_ls);
    logic [31:0] exp_i, exp_d;
    bit          i_busy, d_busy, i_seen, d_seen;
    int          hold, t0, cyc;
    txn_t        t;
    exp_i = exp_inst_rdata;
    exp_d = exp_data_rdata;
    // The data side goes first when both request together (DATA_FIRST=1).
    if (do_d) begin
      t.addr = xlate(da); t.wr = (wen != 4'h0); t.wstrb = wen; t.wdata = wd;
      exp_q.push_back(t);
      if (wen != 4'h0) ref_write(xlate(da), wen, wd);
      else             exp_d = ref_read(xlate(da));
    end
    if (do_i) begin
      t.addr = xlate(ia); t.wr = 1'b0; t.wstrb = 4'h0; t.wdata = 32'h0;
      exp_q.push_back(t);
      exp_i = ref_read(xlate(ia));
    end
    t0 = txn_count; i_busy = do_i; d_busy = do_d; i_seen = 0; d_seen = 0;
    hold = hold_ls; cyc = 0; last_i_cyc = 0; last_d_cyc = 0;
    @(negedge clk);
    inst_sram_en    = do_i;
    inst_sram_addr  = ia;
    data_sram_en    = do_d;
    data_sram_wen   = wen;
    data_sram_addr  = da;
    data_sram_wdata = wd;
    longest_stall   = rand_ls ? 1'($urandom_range(0, 1)) : (hold_ls > 0);
    while ((i_busy || d_busy) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (i_busy && (i_seen || !i_stall)) begin
        if (!i_seen) begin i_seen = 1; last_i_cyc = cyc; end
        check("i_stall_low", 32'(i_stall), 32'd0);
        check("i_rdata", inst_sram_rdata, exp_i);
      end
      if (d_busy && (d_seen || !d_stall)) begin
        if (!d_seen) begin d_seen = 1; last_d_cyc = cyc; end
        check("d_stall_low", 32'(d_stall), 32'd0);
        check("d_rdata", data_sram_rdata, exp_d);
      end
      if (rand_ls) begin
        longest_stall = 1'($urandom_range(0, 1));
      end else if (hold_ls > 0) begin
        if ((i_seen || d_seen) && hold > 0) hold--;
        longest_stall = (hold > 0);
      end else begin
        longest_stall = 1'b0;
      end
      if (i_busy && i_seen && !longest_stall) begin inst_sram_en = 1'b0; i_busy = 0; end
      if (d_busy && d_seen && !longest_stall) begin data_sram_en = 1'b0; d_busy = 0; end
    end
    check("access_timeout", {30'd0, i_busy, d_busy}, 32'd0);
    inst_sram_en  = 1'b0;
    data_sram_en  = 1'b0;
    longest_stall = 1'b0;
    if (do_i) exp_inst_rdata = exp_i;
    if (do_d) exp_data_rdata = exp_d;
    check("txn_count", 32'(txn_count - t0), 32'(int'(do_i) + int'(do_d)));
    if (do_i && do_d) check("d_before_i", 32'(last_d_cyc < last_i_cyc), 32'd1);
    check("i_rdata_keep", inst_sram_rdata, exp_inst_rdata);
    check("d_rdata_keep", data_sram_rdata, exp_data_rdata);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_accept(input int target);
    int n;
    n = 0;
    while (txn_count < target && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_wait", 32'(txn_count >= target), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    case ($urandom_range(0, 4))
      0:       base = 32'h8000_0000;
      1:       base = 32'hA000_0000;
      2:       base = 32'h0000_0000;
      3:       base = 32'h4000_0000;
      default: base = 32'hC000_0000;
    endcase
    return base + 32'($urandom_range(0, 7) << 2);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int n;
    txn_t t;
    rst = 1'b0;
    inst_sram_en = 1'b0; inst_sram_addr = 32'h0;
    data_sram_en = 1'b0; data_sram_wen = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    longest_stall = 1'b0; exceptflush = 1'b0;
    #22 rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_i_stall", 32'(i_stall), 32'd0);
    check("rst_d_stall", 32'(d_stall), 32'd0);
    check("rst_inst_rdata", inst_sram_rdata, 32'd0);
    check("rst_data_rdata", data_sram_rdata, 32'd0);

    // Single fetch from the boot vector, minimum latency
    preload(32'h1FC0_0000, 32'h3C08_0001);
    access(1'b1, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 0);
    check("fetch_latency", 32'(last_i_cyc), 32'd3);
    check("fetch_word", inst_sram_rdata, 32'h3C08_0001);

    // Fetch and store raised together: the store goes first
    access(1'b1, 32'hBFC0_0004, 1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 0);
    check("store_latency", 32'(last_d_cyc), 32'd3);
    check("fetch_after_store", 32'(last_i_cyc), 32'd6);
    access(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0010, 32'h0, 1'b0, 0);
    check("store_readback", data_sram_rdata, 32'hDEAD_BEEF);

    // Load completing under a frozen pipeline, then a fresh load right after
    access(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0040, 32'h0, 1'b0, 6);
    check("held_load_latency", 32'(last_d_cyc), 32'd3);
    access(1'b0, 32'h0, 1'b1, 4'h0, 32'hA000_0044, 32'h0, 1'b0, 0);
    check("load_after_hold", 32'(last_d_cyc), 32'd3);

    // addr_ok delayed by 4 cycles
    addr_delay = 4;
    access(1'b0, 32'h0, 1'b1, 4'b0110, 32'h0000_0080, 32'h1357_9BDF, 1'b0, 0);
    check("slow_addr_latency", 32'(last_d_cyc), 32'd7);
    addr_delay = 0;

    // Flush while the fetch waits for data, then the redirected fetch
    preload(32'h1FC0_0100, 32'h0BAD_0BAD);
    preload(32'h1FC0_0380, 32'h2408_0380);
    t.wr = 1'b0; t.wstrb = 4'h0; t.wdata = 32'h0;
    t.addr = 32'h1FC0_0100; exp_q.push_back(t);
    t.addr = 32'h1FC0_0380; exp_q.push_back(t);
    data_delay = 3;
    t0 = txn_count;
    @(negedge clk);
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0100;
    wait_accept(t0 + 1);
    @(negedge clk);
    exceptflush = 1'b1; inst_sram_addr = 32'hBFC0_0380;
    @(negedge clk);
    exceptflush = 1'b0;
    n = 0;
    while (i_stall && n < 60) begin
      check("flush_rdata_held", inst_sram_rdata, exp_inst_rdata);
      @(negedge clk);
      n++;
    end
    check("flush_txns", 32'(txn_count - t0), 32'd2);
    check("flush_i_stall_low", 32'(i_stall), 32'd0);
    check("flush_new_word", inst_sram_rdata, 32'h2408_0380);
    inst_sram_en = 1'b0;
    exp_inst_rdata = 32'h2408_0380;
    data_delay = 0;
    check("flush_exp_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while a store is in D_DATA
    t.addr = 32'h0000_2000; t.wr = 1'b1; t.wstrb = 4'b0011; t.wdata = 32'h1234_5678;
    exp_q.push_back(t);
    data_delay = 3;
    t0 = txn_count;
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_wen = 4'b0011;
    data_sram_addr = 32'h0000_2000; data_sram_wdata = 32'h1234_5678;
    wait_accept(t0 + 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_mem_wr", 32'(mem_wr), 32'd0);
    check("arst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    check("arst_mem_wdata", mem_wdata, 32'd0);
    check("arst_inst_rdata", inst_sram_rdata, 32'd0);
    check("arst_data_rdata", data_sram_rdata, 32'd0);
    check("arst_d_stall", 32'(d_stall), 32'd1);
    @(negedge clk);
    data_sram_en = 1'b0;
    exp_inst_rdata = 32'h0;
    exp_data_rdata = 32'h0;
    data_delay = 0;
    #2 rst = 1'b1;
    access(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_2000, 32'h0, 1'b0, 0);
    check("post_rst_latency", 32'(last_d_cyc), 32'd3);

    // Randomized traffic with random memory latency and pipeline freezes
    rand_delays = 1'b1;
    for (int k = 0; k < 150; k++) begin
      int          kind;
      logic [3:0]  wen;
      kind = $urandom_range(0, 2);
      wen  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      access(kind != 1, rand_addr(), kind != 0, wen, rand_addr(), $urandom, 1'b1, 0);
    end
    rand_delays = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
